forwarding_hazard_unit: RTL and testbench
=========================================

# forwarding_hazard_unit

Generates the 2-bit operand selects for the two 3:1 ALU-operand forwarding muxes (A and B) in the EX stage of the 5-stage MIPS pipeline, and detects load-use hazards. It keeps its own shadow copy of destination-register info for the EX, MEM and WB slots, fed from ID each cycle. It registers the selects so they are valid for the whole cycle the instruction occupies EX, and asserts a one-cycle stall on load-use.

## Interface
- No parameters; register index width fixed at 5, select width fixed at 2.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source register A
- id_rt  in  5  ID source register B
- id_uses_rt  in  1  ID instruction reads rt as an operand (R-type, branch, store)
- id_rd  in  5  ID destination register (already resolved rd/rt)
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  squash the ID instruction (taken branch/jump)
- fwd_a_sel  out  2  select for operand-A mux, registered
- fwd_b_sel  out  2  select for operand-B mux, registered
- stall  out  1  hold PC and IF/ID, bubble into EX; combinational
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- Select encoding matches the mux: 00 = register-file value, 01 = MEM/WB result, 10 = EX/MEM ALU result. 11 is never driven; the mux outputs z on 11.
- Shadow slots EX, MEM, WB each hold {valid, rd, regwrite, memread}. Every cycle: WB<=MEM, MEM<=EX, EX<=ID entry or bubble.
- The EX slot loads a bubble (valid=0) when stall=1, flush=1 or id_valid=0.
- A slot "writes r" iff valid & regwrite & rd==r & r!=0. Register $0 is never forwarded.
- On each ID->EX advance (no stall, no flush), compute for src in {rs, rt}:
  - If the EX slot writes src, select 10. Its result will be in EX/MEM.
  - Else if the MEM slot writes src, select 01.
  - Else 00.
  - The newest producer wins.
- fwd_b_sel is forced to 00 when id_uses_rt=0.
- When a bubble enters EX, both selects go to 00.
- Load-use: stall=1 when id_valid & !flush & EX slot is valid & memread & rd!=0 & (rd==id_rs | (id_uses_rt & rd==id_rt)).
- FSM RUN/STALL:
  - RUN->STALL when stall asserts.
  - STALL->RUN unconditionally on the next cycle.
  - In STALL, the bubble now occupies EX, so stall cannot re-assert for the same load. At most one stall cycle per load-use.
  - After the stall, the load sits in MEM, so the consumer gets select 01.
- flush and a hazard together: flush wins. stall=0, the EX slot gets a bubble, and stall_count is unchanged.

## Timing
- Reset (rst high at a clk edge):
  - All slots invalid; FSM to RUN.
  - fwd_a_sel=fwd_b_sel=00, stall=0, stall_count=0.
- Reset mid-operation discards all in-flight slot state on that edge.
- Select latency: computed in ID, registered on the edge the instruction enters EX, and stable for that EX cycle.
- stall is combinational from ID inputs and slot state, valid in the same cycle. The upstream holds its ID inputs stable during a stall.
- stall_count increments on each edge where stall=1 and saturates at 16'hFFFF.

## Configuration
- FWD_STATS_EN defined: stall_count is implemented as described.
- FWD_STATS_EN undefined: no counter register; stall_count is tied to 16'd0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with random ID inputs -> selects 00, stall 0, stall_count 0.
- EX-EX forwarding: add $3 (regwrite, rd=3), then sub using rs=3, rt=4 next cycle -> in sub's EX cycle fwd_a_sel=10, fwd_b_sel=00.
- MEM forwarding and priority:
  - Writer of $5, one independent instruction, then a reader of rs=5 -> fwd_a_sel=01.
  - Writers of $5 in two consecutive instructions, then a reader -> fwd_a_sel=10.
- Load-use: lw rd=7, then add rs=7 -> stall=1 for exactly one cycle; then add enters EX with fwd_a_sel=01; stall_count=1.
- $0 and rt-unused:
  - Writer of rd=0 followed by a reader of rs=0 -> select 00.
  - lw rd=8 followed by addi with rt=8 and id_uses_rt=0 -> no stall, fwd_b_sel=00.
- Flush versus hazard: the load-use pair from the load-use test with flush=1 on the consumer's ID cycle -> stall=0, bubble enters EX with selects 00, stall_count unchanged. With FWD_STATS_EN undefined, stall_count stays 0 throughout.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - EX-stage operand forwarding selects and load-use stall detection
//
// Purpose:
//   Tracks destination-register info for the instructions ahead of ID and
//   produces registered 3:1 forwarding-mux selects for ALU operands A and B,
//   plus a combinational one-cycle stall on a load-use hazard.
//
// Configuration macro:
//   FWD_STATS_EN - when defined, stall_count is a saturating count of stall
//                  cycles; when undefined, stall_count is tied to zero.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   id_valid     in   ID holds a real instruction
//   id_rs        in   ID source register A
//   id_rt        in   ID source register B
//   id_uses_rt   in   ID instruction reads rt as an operand
//   id_rd        in   ID destination register (resolved rd/rt)
//   id_regwrite  in   ID instruction writes the register file
//   id_memread   in   ID instruction is a load
//   flush        in   squash the ID instruction
//   fwd_a_sel    out  operand-A select (00 regfile, 01 MEM/WB, 10 EX/MEM), registered
//   fwd_b_sel    out  operand-B select, same encoding, registered
//   stall        out  hold PC and IF/ID, bubble into EX; combinational
//   stall_count  out  saturating count of load-use stall cycles

module forwarding_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ex_slot_t;

  // Only EX needs memread (load-use). The WB slot is not kept: the operand mux
  // has no WB input, and a value in WB reaches the consumer through the
  // register file's write-before-read, so nothing would ever read it.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } mem_slot_t;

  typedef enum logic {RUN, STALL} state_t;

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q;
  state_t    state_q, state_d;
  logic      hazard;
  logic      advance;
  logic [1:0] a_d, b_d;

  function automatic logic ex_writes(input ex_slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
  endfunction

  function automatic logic mem_writes(input mem_slot_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
  endfunction

  // Load in EX whose result an ID operand needs; flush suppresses it.
  assign hazard = id_valid && !flush && ex_q.valid && ex_q.memread &&
                  (ex_q.rd != 5'd0) &&
                  ((ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt)));

  // In STALL the bubble already sits in EX, so the gate only makes the
  // one-stall-per-load guarantee explicit.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall   = 1'b1;
          state_d = STALL;
        end
      end
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign advance = id_valid && !flush && !stall;

  // Selects look at the slots as they are now: the current EX occupant will be
  // in EX/MEM when ID reaches EX (10), the current MEM occupant in MEM/WB (01).
  always_comb begin
    ex_d = '0;
    a_d  = 2'b00;
    b_d  = 2'b00;
    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      if (ex_writes(ex_q, id_rs))       a_d = 2'b10;
      else if (mem_writes(mem_q, id_rs)) a_d = 2'b01;
      if (id_uses_rt) begin
        if (ex_writes(ex_q, id_rt))       b_d = 2'b10;
        else if (mem_writes(mem_q, id_rt)) b_d = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      state_q   <= RUN;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else begin
      ex_q           <= ex_d;
      mem_q.valid    <= ex_q.valid;
      mem_q.rd       <= ex_q.rd;
      mem_q.regwrite <= ex_q.regwrite;
      state_q        <= state_d;
      fwd_a_sel      <= a_d;
      fwd_b_sel      <= b_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else if (stall && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign stall_count = count_q;
`else
  assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - self-checking bench for forwarding_hazard_unit

module tb_forwarding_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic [15:0] stall_count;

  forwarding_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } instr_t;

  // History of what entered EX, newest at the back.
  instr_t hist[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     stalls   = 0;
  logic   obs_stall;
  logic   last_stall = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit produces(input instr_t s, input bit [4:0] r);
    return s.v && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef FWD_STATS_EN
    return (stalls > 65535) ? 16'hFFFF : 16'(stalls);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_clear();
    instr_t b;
    b = '{v: 0, rd: 0, rw: 0, mr: 0};
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    stalls     = 0;
    last_stall = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      id_valid    = 1'($urandom);
      id_rs       = 5'($urandom);
      id_rt       = 5'($urandom);
      id_uses_rt  = 1'($urandom);
      id_rd       = 5'($urandom);
      id_regwrite = 1'($urandom);
      id_memread  = 1'($urandom);
      flush       = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_a", 16'(fwd_a_sel), 16'd0);
    check("rst_b", 16'(fwd_b_sel), 16'd0);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_cnt", stall_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One cycle: drive ID, check stall, advance, check selects and count.
  task automatic step(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit ut,
                      input bit [4:0] rd, input bit rw, input bit mr, input bit fl);
    instr_t ex, mem, nw;
    bit     es;
    bit [1:0] ea, eb;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
    id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    ex  = hist[hist.size()-1];
    mem = hist[hist.size()-2];
    es  = v && !fl && ex.v && ex.mr && (ex.rd != 0) &&
          ((ex.rd == rs) || (ut && (ex.rd == rt)));
    obs_stall = stall;
    check("stall", 16'(stall), 16'(es));
    ea = 2'b00;
    eb = 2'b00;
    nw = '{v: 0, rd: 0, rw: 0, mr: 0};
    if (v && !fl && !es) begin
      nw = '{v: 1, rd: rd, rw: rw, mr: mr};
      ea = produces(ex, rs) ? 2'd2 : produces(mem, rs) ? 2'd1 : 2'd0;
      if (ut) eb = produces(ex, rt) ? 2'd2 : produces(mem, rt) ? 2'd1 : 2'd0;
    end
    if (es) stalls++;
    hist.push_back(nw);
    if (hist.size() > 4) void'(hist.pop_front());
    last_stall = es;
    @(posedge clk);
    #1;
    check("sel_a", 16'(fwd_a_sel), 16'(ea));
    check("sel_b", 16'(fwd_b_sel), 16'(eb));
    check("count", stall_count, exp_count());
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] c0;
    bit v, ut, rw, mr, fl;
    bit [4:0] rs, rt, rd;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
    reset_dut();

    // EX-EX forwarding
    step(1, 1, 2, 1, 3, 1, 0, 0);
    step(1, 3, 4, 1, 6, 1, 0, 0);
    check("exex_a", 16'(fwd_a_sel), 16'd2);
    check("exex_b", 16'(fwd_b_sel), 16'd0);

    // MEM forwarding
    nop(); nop();
    step(1, 1, 2, 1, 5, 1, 0, 0);
    step(1, 1, 2, 1, 9, 1, 0, 0);
    step(1, 5, 0, 0, 10, 1, 0, 0);
    check("mem_a", 16'(fwd_a_sel), 16'd1);

    // Newest producer wins
    nop(); nop();
    step(1, 1, 2, 1, 5, 1, 0, 0);
    step(1, 1, 2, 1, 5, 1, 0, 0);
    step(1, 5, 0, 0, 10, 1, 0, 0);
    check("prio_a", 16'(fwd_a_sel), 16'd2);

    // Load-use
    nop(); nop();
    c0 = stall_count;
    step(1, 1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 2, 1, 11, 1, 0, 0);
    check("lu_stall1", 16'(obs_stall), 16'd1);
    step(1, 7, 2, 1, 11, 1, 0, 0);
    check("lu_stall2", 16'(obs_stall), 16'd0);
    check("lu_a", 16'(fwd_a_sel), 16'd1);
`ifdef FWD_STATS_EN
    check("lu_cnt", stall_count, c0 + 16'd1);
`else
    check("lu_cnt", stall_count, 16'd0);
`endif

    // $0 never forwarded
    nop(); nop();
    step(1, 1, 2, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 12, 1, 0, 0);
    check("zero_a", 16'(fwd_a_sel), 16'd0);
    check("zero_b", 16'(fwd_b_sel), 16'd0);

    // rt unused: no stall, no B forwarding
    nop(); nop();
    step(1, 1, 0, 0, 8, 1, 1, 0);
    step(1, 1, 8, 0, 13, 1, 0, 0);
    check("nort_stall", 16'(obs_stall), 16'd0);
    check("nort_b", 16'(fwd_b_sel), 16'd0);

    // Flush beats hazard
    nop(); nop();
    c0 = stall_count;
    step(1, 1, 0, 0, 7, 1, 1, 0);
    step(1, 7, 7, 1, 11, 1, 0, 1);
    check("fl_stall", 16'(obs_stall), 16'd0);
    check("fl_a", 16'(fwd_a_sel), 16'd0);
    check("fl_b", 16'(fwd_b_sel), 16'd0);
    check("fl_cnt", stall_count, c0);

    // Randomized traffic; ID inputs held while stalled
    v = 0; rs = 0; rt = 0; ut = 0; rd = 0; rw = 0; mr = 0; fl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        v  = ($urandom_range(0, 9) != 0);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        ut = 1'($urandom);
        rd = 5'($urandom_range(0, 7));
        rw = ($urandom_range(0, 3) != 0);
        mr = ($urandom_range(0, 2) == 0);
        fl = ($urandom_range(0, 15) == 0);
      end
      step(v, rs, rt, ut, rd, rw, mr, fl);
    end

    // Reset mid-operation discards the in-flight load
    step(1, 1, 0, 0, 7, 1, 1, 0);
    reset_dut();
    step(1, 7, 7, 1, 11, 1, 0, 0);
    check("rst_mid_stall", 16'(obs_stall), 16'd0);
    check("rst_mid_a", 16'(fwd_a_sel), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
